task_issuer: RTL and testbench

Command-side counterpart to the arithmetic task state machine (opcode in, done out). It buffers opcodes from a host in a small FIFO and issues them one at a time to the worker. Each opcode is held stable until the worker pulses done, or until a timeout expires. It reports busy status, a completion count and sticky error flags. It sits between host/control logic and the state_machine worker.

---
 rtl/task_issuer_if.sv | 19 +
 rtl/task_issuer.sv | 100 ++++++++++
 tb/tb_task_issuer.sv | 216 +++++++++++++++++++++
 3 files changed

// File: rtl/task_issuer_if.sv
// rtl/task_issuer_if.sv - host command and worker issue handshake bundle
interface task_issuer_if;
  logic       cmd_valid;
  logic [1:0] cmd_opcode;
  logic       cmd_ready;
  logic [1:0] opcode;
  logic       start;
  logic       done;

  modport master (
    output cmd_valid, cmd_opcode, done,
    input  cmd_ready, opcode, start
  );

  modport slave (
    input  cmd_valid, cmd_opcode, done,
    output cmd_ready, opcode, start
  );
endinterface

// File: rtl/task_issuer.sv
// rtl/task_issuer.sv - buffers host opcodes and issues them one at a time to a worker
module task_issuer #(
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 16,
  parameter int CNTW    = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  task_issuer_if.slave             bus,
  output logic                     busy,
  output logic [$clog2(DEPTH):0]   fifo_count,
  output logic [CNTW-1:0]          completed_count,
  output logic                     timeout_err,
  output logic                     illegal_err
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int TW = $clog2(TIMEOUT);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RETIRE} state_t;

  state_t        state, next_state;
  logic [1:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [TW-1:0] timer;
  logic [1:0]    head;
  logic [1:0]    opcode_q;
  logic          start_q;
  logic          push, pop, timeout_hit;

  assign head        = mem[rd_ptr];
  assign bus.cmd_ready = (fifo_count != CW'(DEPTH));
  assign push        = bus.cmd_valid & bus.cmd_ready;
  assign pop         = (state == ISSUE);
  assign timeout_hit = (timer == TW'(TIMEOUT - 1));
  assign busy        = (state != IDLE) || (fifo_count != '0);
  assign bus.opcode  = opcode_q;
  assign bus.start   = start_q;

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (fifo_count != '0) next_state = ISSUE;
      ISSUE:   next_state = (head == 2'd3) ? IDLE : WAIT;
      // done outranks the timeout when both land on the last WAIT cycle
      WAIT:    if (bus.done)        next_state = RETIRE;
               else if (timeout_hit) next_state = IDLE;
      RETIRE:  next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Storage is flushed by the pointer reset; entries themselves need no reset.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= bus.cmd_opcode;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr          <= '0;
      rd_ptr          <= '0;
      fifo_count      <= '0;
      timer           <= '0;
      opcode_q        <= '0;
      start_q         <= 1'b0;
      completed_count <= '0;
      timeout_err     <= 1'b0;
      illegal_err     <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   fifo_count <= fifo_count + CW'(1);
        2'b01:   fifo_count <= fifo_count - CW'(1);
        default: fifo_count <= fifo_count;
      endcase

      start_q <= 1'b0;
      if (state == ISSUE) begin
        timer <= '0;
        if (head == 2'd3) begin
          illegal_err <= 1'b1;
        end else begin
          opcode_q <= head;
          start_q  <= 1'b1;
        end
      end else if (state == WAIT) begin
        timer <= timer + TW'(1);
      end

      if (state == WAIT && !bus.done && timeout_hit) timeout_err <= 1'b1;
      if (state == RETIRE) completed_count <= completed_count + CNTW'(1);
    end
  end
endmodule

// File: tb/tb_task_issuer.sv
// tb/tb_task_issuer.sv - randomized self-checking bench for task_issuer against a queue-based model
module tb_task_issuer;
  localparam int DEPTH   = 4;
  localparam int TIMEOUT = 16;
  localparam int CNTW    = 8;
  localparam int M_IDLE = 0, M_ISSUE = 1, M_WAIT = 2, M_RETIRE = 3;

  logic clk = 1'b0;
  logic reset;
  logic busy;
  logic [$clog2(DEPTH):0] fifo_count;
  logic [CNTW-1:0] completed_count;
  logic timeout_err, illegal_err;

  always #5 clk = ~clk;

  task_issuer_if bus ();

  task_issuer #(.DEPTH(DEPTH), .TIMEOUT(TIMEOUT), .CNTW(CNTW)) dut (
    .clk             (clk),
    .reset           (reset),
    .bus             (bus.slave),
    .busy            (busy),
    .fifo_count      (fifo_count),
    .completed_count (completed_count),
    .timeout_err     (timeout_err),
    .illegal_err     (illegal_err)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Reference model: a queue of pending opcodes plus the life-cycle of the single outstanding task.
  int mq[$];
  int m_ph = M_IDLE, m_age = 0, m_op = 0, m_cnt = 0;
  bit m_start = 0, m_terr = 0, m_ierr = 0, m_pushed = 0;

  // Worker: done_delay >= 0 fixed delay, -1 never, -2 random per task.
  int  wc = -1;
  int  done_delay = 4;
  bit  spurious = 0;

  task automatic model_step();
    int h;
    bit pv;
    pv = bus.cmd_valid && (mq.size() != DEPTH);
    if (reset) begin
      mq.delete();
      m_ph = M_IDLE; m_age = 0; m_op = 0; m_cnt = 0;
      m_start = 0; m_terr = 0; m_ierr = 0; m_pushed = 0;
      return;
    end
    m_pushed = pv;
    m_start  = 0;
    case (m_ph)
      M_IDLE:   if (mq.size() != 0) m_ph = M_ISSUE;
      M_ISSUE: begin
        h = mq.pop_front();
        if (h == 3) begin
          m_ierr = 1;
          m_ph = M_IDLE;
        end else begin
          m_op = h; m_start = 1; m_age = 0; m_ph = M_WAIT;
        end
      end
      M_WAIT: begin
        if (bus.done) m_ph = M_RETIRE;
        else if (m_age == TIMEOUT - 1) begin
          m_terr = 1; m_ph = M_IDLE;
        end else m_age++;
      end
      default: begin
        m_cnt = (m_cnt + 1) % (1 << CNTW);
        m_ph = M_IDLE;
      end
    endcase
    if (pv) mq.push_back(int'(bus.cmd_opcode));
  endtask

  task automatic compare_all();
    check_eq("opcode", 32'(bus.opcode), m_op);
    check_eq("start", 32'(bus.start), 32'(m_start));
    check_eq("cmd_ready", 32'(bus.cmd_ready), 32'(mq.size() != DEPTH));
    check_eq("busy", 32'(busy), 32'(m_ph != M_IDLE || mq.size() != 0));
    check_eq("fifo_count", 32'(fifo_count), mq.size());
    check_eq("completed_count", 32'(completed_count), m_cnt);
    check_eq("timeout_err", 32'(timeout_err), 32'(m_terr));
    check_eq("illegal_err", 32'(illegal_err), 32'(m_ierr));
  endtask

  task automatic worker_drive();
    if (m_start) begin
      if (done_delay == -2) wc = ($urandom_range(0, 4) == 0) ? -1 : $urandom_range(0, TIMEOUT + 1);
      else wc = done_delay;
    end
    if (spurious) begin
      bus.done = ($urandom_range(0, 2) == 0);
    end else if (wc == 0) begin
      bus.done = 1'b1;
      wc = -1;
    end else begin
      bus.done = 1'b0;
      if (wc > 0) wc--;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
    compare_all();
    worker_drive();
  endtask

  task automatic push_cmd(input int op);
    bus.cmd_valid  = 1'b1;
    bus.cmd_opcode = 2'(op);
    for (int i = 0; i < 200; i++) begin
      tick();
      if (m_pushed) break;
    end
    check_eq("push_accept", 32'(m_pushed), 1);
    bus.cmd_valid = 1'b0;
  endtask

  task automatic run_until_idle(input int bound);
    for (int i = 0; i < bound; i++) begin
      if (m_ph == M_IDLE && mq.size() == 0) break;
      tick();
    end
    check_eq("drain", 32'(busy), 0);
  endtask

  initial begin
    reset = 1'b1;
    bus.cmd_valid = 1'b0;
    bus.cmd_opcode = 2'd0;
    bus.done = 1'b0;
    repeat (2) tick();
    reset = 1'b0;
    tick();

    // In-order issue with a 4-cycle worker
    done_delay = 4;
    push_cmd(0); push_cmd(1); push_cmd(2);
    run_until_idle(100);
    check_eq("three_done", 32'(completed_count), 3);

    // Stalled worker fills the FIFO; later pushes wait for a pop
    done_delay = 10;
    for (int i = 0; i < 7; i++) push_cmd(i % 3);
    run_until_idle(400);

    // Illegal opcode dropped, next legal one issues
    done_delay = 2;
    push_cmd(3); push_cmd(1);
    run_until_idle(100);
    check_eq("illegal_seen", 32'(illegal_err), 1);

    // Timeouts and the done-on-last-cycle boundary
    done_delay = -1;
    push_cmd(2); push_cmd(0);
    run_until_idle(200);
    check_eq("timeout_seen", 32'(timeout_err), 1);
    done_delay = TIMEOUT - 1;
    push_cmd(1);
    run_until_idle(100);
    done_delay = TIMEOUT;
    push_cmd(0);
    run_until_idle(100);

    // Reset in WAIT with two entries queued, late done afterwards
    done_delay = -1;
    push_cmd(0); push_cmd(1); push_cmd(2);
    for (int i = 0; i < 20; i++) begin
      if (m_ph == M_WAIT && mq.size() == 2) break;
      tick();
    end
    check_eq("reached_wait", 32'(mq.size()), 2);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    wc = 1;
    check_eq("rst_fifo", 32'(fifo_count), 0);
    check_eq("rst_terr", 32'(timeout_err), 0);
    repeat (6) tick();
    spurious = 1;
    repeat (12) tick();
    spurious = 0;
    check_eq("late_done_ignored", 32'(completed_count), 0);

    // Randomized traffic with random worker latency and occasional reset
    done_delay = -2;
    for (int i = 0; i < 3000; i++) begin
      bus.cmd_valid  = ($urandom_range(0, 2) == 0);
      bus.cmd_opcode = 2'($urandom_range(0, 3));
      reset = ($urandom_range(0, 399) == 0);
      tick();
    end
    reset = 1'b0;
    bus.cmd_valid = 1'b0;
    done_delay = 3;
    run_until_idle(600);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
